// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: register update commands,
// controller states and the execute-counter width.
package pipe_ctrl_pkg;

    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        HOLD  = 2'b00,
        LOAD  = 2'b01,
        FLUSH = 2'b10
    } update_t;

    typedef enum logic [1:0] {
        StRun      = 2'b00,
        StExecWait = 2'b01,
        StMemWait  = 2'b10,
        StHalt     = 2'b11
    } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check: the D instruction reads a register that the load
// in E has not produced yet. r0 never creates a dependency.
module hazard_detect (
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic       d_uses_rs,
    input  logic       d_uses_rt,
    input  logic [4:0] de_rd,
    input  logic       de_is_load,
    output logic       hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = d_uses_rs && (d_rs == de_rd);
    assign rt_match = d_uses_rt && (d_rt == de_rd);
    assign hazard   = de_is_load && (de_rd != 5'd0) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: sequences F/D, D/E and E/W register updates and the PC
// around multi-cycle execute, memory wait, redirects, load-use and stop.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic        d_uses_rs,
    input  logic        d_uses_rt,
    input  logic [4:0]  de_rd,
    input  logic        de_is_load,
    input  logic        de_mem,
    input  logic        mem_ready,
    input  logic [4:0]  de_counter,
    input  logic        e_redirect,
    input  logic        de_stop,
    output logic [1:0]  fd_update,
    output logic [1:0]  de_update,
    output logic [1:0]  ew_update,
    output logic        pc_en,
    output logic        mem_req,
    output logic        halted,
    output logic [31:0] stall_cnt
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_q;
    update_t          fd_cmd, de_cmd, ew_cmd;
    logic             pc_en_int, mem_req_int, halted_int;
    logic             do_adv, skip_mem, hazard;

    hazard_detect u_hazard (
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_uses_rs  (d_uses_rs),
        .d_uses_rt  (d_uses_rt),
        .de_rd      (de_rd),
        .de_is_load (de_is_load),
        .hazard     (hazard)
    );

    always_comb begin
        fd_cmd      = HOLD;
        de_cmd      = HOLD;
        ew_cmd      = HOLD;
        pc_en_int   = 1'b0;
        mem_req_int = 1'b0;
        halted_int  = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        do_adv      = 1'b0;
        skip_mem    = 1'b0;

        unique case (state_q)
            StRun: begin
                if (de_counter != 5'd0) begin
                    ew_cmd  = FLUSH;
                    cnt_d   = de_counter - 5'd1;
                    state_d = StExecWait;
                end else begin
                    do_adv      = 1'b1;
                    mem_req_int = de_mem;
                end
            end
            StExecWait: begin
                if (cnt_q != '0) begin
                    ew_cmd = FLUSH;
                    cnt_d  = cnt_q - 5'd1;
                end else begin
                    do_adv      = 1'b1;
                    mem_req_int = de_mem;
                end
            end
            StMemWait: begin
                mem_req_int = de_mem;
                if (!mem_ready) begin
                    ew_cmd = FLUSH;
                end else begin
                    do_adv   = 1'b1;
                    skip_mem = 1'b1;
                end
            end
            StHalt: begin
                halted_int = 1'b1;
            end
        endcase

        // Advance: fixed priority mem-wait > stop > redirect > load-use > normal.
        if (do_adv) begin
            state_d = StRun;
            if (!skip_mem && de_mem && !mem_ready) begin
                ew_cmd  = FLUSH;
                state_d = StMemWait;
            end else if (de_stop) begin
                fd_cmd  = FLUSH;
                de_cmd  = FLUSH;
                ew_cmd  = LOAD;
                state_d = StHalt;
            end else if (e_redirect) begin
                fd_cmd    = FLUSH;
                de_cmd    = FLUSH;
                ew_cmd    = LOAD;
                pc_en_int = 1'b1;
            end else if (hazard) begin
                de_cmd = FLUSH;
                ew_cmd = LOAD;
            end else begin
                fd_cmd    = LOAD;
                de_cmd    = LOAD;
                ew_cmd    = LOAD;
                pc_en_int = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StRun;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!pc_en_int && (state_q != StHalt)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    // Reset forces every command output quiet regardless of registered state.
    assign fd_update = rstn ? fd_cmd : HOLD;
    assign de_update = rstn ? de_cmd : HOLD;
    assign ew_update = rstn ? ew_cmd : HOLD;
    assign pc_en     = rstn & pc_en_int;
    assign mem_req   = rstn & mem_req_int;
    assign halted    = rstn & halted_int;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  d_rs, d_rt, de_rd, de_counter;
    logic        d_uses_rs, d_uses_rt, de_is_load, de_mem, mem_ready, e_redirect, de_stop;
    logic [1:0]  fd_update, de_update, ew_update;
    logic        pc_en, mem_req, halted;
    logic [31:0] stall_cnt;

    logic [40:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          step = 0;
    string       phase = "init";

    pipe_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_uses_rs  (d_uses_rs),
        .d_uses_rt  (d_uses_rt),
        .de_rd      (de_rd),
        .de_is_load (de_is_load),
        .de_mem     (de_mem),
        .mem_ready  (mem_ready),
        .de_counter (de_counter),
        .e_redirect (e_redirect),
        .de_stop    (de_stop),
        .fd_update  (fd_update),
        .de_update  (de_update),
        .ew_update  (ew_update),
        .pc_en      (pc_en),
        .mem_req    (mem_req),
        .halted     (halted),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: the controller presents a response every cycle.
    always @(negedge clk) begin
        logic [40:0] act;
        logic [40:0] exp;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            act = {fd_update, de_update, ew_update, pc_en, mem_req, halted, stall_cnt};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL %s step %0d: got fd/de/ew=%b/%b/%b pc=%b mreq=%b halt=%b stall=%0d, want fd/de/ew=%b/%b/%b pc=%b mreq=%b halt=%b stall=%0d",
                         phase, step, act[40:39], act[38:37], act[36:35], act[34], act[33],
                         act[32], act[31:0], exp[40:39], exp[38:37], exp[36:35], exp[34],
                         exp[33], exp[32], exp[31:0]);
            end
        end
    end

    task automatic clr();
        d_rs = 5'd1; d_rt = 5'd2; d_uses_rs = 1'b1; d_uses_rt = 1'b1;
        de_rd = 5'd9; de_is_load = 1'b0; de_mem = 1'b0; mem_ready = 1'b0;
        de_counter = 5'd0; e_redirect = 1'b0; de_stop = 1'b0;
    endtask

    // Inputs for this cycle are already set; record the expected response.
    task automatic cyc(input logic [1:0] fd, input logic [1:0] de, input logic [1:0] ew,
                       input logic pc, input logic mr, input logic h, input int st);
        exp_q.push_back({fd, de, ew, pc, mr, h, 32'(st)});
        step++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        phase = "reset";
        cyc(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        rstn = 1'b1;

        phase = "straight";
        cyc(2'b01, 2'b01, 2'b01, 1, 0, 0, 0);
        d_rs = 5'd9; d_uses_rs = 1'b0;
        cyc(2'b01, 2'b01, 2'b01, 1, 0, 0, 0);
        clr(); de_mem = 1'b1; mem_ready = 1'b1;
        cyc(2'b01, 2'b01, 2'b01, 1, 1, 0, 0);

        phase = "loaduse_rs";
        clr(); de_is_load = 1'b1; de_rd = 5'd5; d_rs = 5'd5;
        cyc(2'b00, 2'b10, 2'b01, 0, 0, 0, 0);
        clr();
        cyc(2'b01, 2'b01, 2'b01, 1, 0, 0, 1);
        phase = "loaduse_r0";
        de_is_load = 1'b1; de_rd = 5'd0; d_rs = 5'd0;
        cyc(2'b01, 2'b01, 2'b01, 1, 0, 0, 1);
        phase = "loaduse_rt";
        clr(); de_is_load = 1'b1; de_rd = 5'd7; d_rt = 5'd7; d_uses_rs = 1'b0;
        cyc(2'b00, 2'b10, 2'b01, 0, 0, 0, 1);
        clr();
        cyc(2'b01, 2'b01, 2'b01, 1, 0, 0, 2);
        phase = "rt_unused";
        de_is_load = 1'b1; de_rd = 5'd7; d_rt = 5'd7; d_uses_rt = 1'b0;
        cyc(2'b01, 2'b01, 2'b01, 1, 0, 0, 2);

        phase = "exec3";
        clr(); de_counter = 5'd3; de_mem = 1'b1; mem_ready = 1'b1;
        cyc(2'b00, 2'b00, 2'b10, 0, 0, 0, 2);
        cyc(2'b00, 2'b00, 2'b10, 0, 0, 0, 3);
        cyc(2'b00, 2'b00, 2'b10, 0, 0, 0, 4);
        cyc(2'b01, 2'b01, 2'b01, 1, 1, 0, 5);
        clr();
        cyc(2'b01, 2'b01, 2'b01, 1, 0, 0, 5);

        phase = "memwait";
        de_mem = 1'b1; mem_ready = 1'b0;
        cyc(2'b00, 2'b00, 2'b10, 0, 1, 0, 5);
        cyc(2'b00, 2'b00, 2'b10, 0, 1, 0, 6);
        mem_ready = 1'b1;
        cyc(2'b01, 2'b01, 2'b01, 1, 1, 0, 7);
        phase = "memwait_hazard";
        mem_ready = 1'b0;
        cyc(2'b00, 2'b00, 2'b10, 0, 1, 0, 7);
        mem_ready = 1'b1; de_is_load = 1'b1; de_rd = 5'd3; d_rs = 5'd3;
        cyc(2'b00, 2'b10, 2'b01, 0, 1, 0, 8);
        clr();
        cyc(2'b01, 2'b01, 2'b01, 1, 0, 0, 9);

        phase = "redirect_hazard";
        de_is_load = 1'b1; de_rd = 5'd4; d_rs = 5'd4; e_redirect = 1'b1;
        cyc(2'b10, 2'b10, 2'b01, 1, 0, 0, 9);
        clr();
        cyc(2'b01, 2'b01, 2'b01, 1, 0, 0, 9);
        phase = "exec_redirect";
        de_counter = 5'd1; e_redirect = 1'b1;
        cyc(2'b00, 2'b00, 2'b10, 0, 0, 0, 9);
        cyc(2'b10, 2'b10, 2'b01, 1, 0, 0, 10);
        clr();
        cyc(2'b01, 2'b01, 2'b01, 1, 0, 0, 10);

        phase = "stop";
        de_stop = 1'b1;
        cyc(2'b10, 2'b10, 2'b01, 0, 0, 0, 10);
        phase = "halt";
        clr(); e_redirect = 1'b1; de_mem = 1'b1;
        cyc(2'b00, 2'b00, 2'b00, 0, 0, 1, 11);
        clr();
        cyc(2'b00, 2'b00, 2'b00, 0, 0, 1, 11);
        phase = "halt_reset";
        rstn = 1'b0;
        cyc(2'b00, 2'b00, 2'b00, 0, 0, 0, 11);
        rstn = 1'b1;
        cyc(2'b01, 2'b01, 2'b01, 1, 0, 0, 0);

        phase = "exec_reset";
        de_counter = 5'd5;
        cyc(2'b00, 2'b00, 2'b10, 0, 0, 0, 0);
        cyc(2'b00, 2'b00, 2'b10, 0, 0, 0, 1);
        rstn = 1'b0;
        cyc(2'b00, 2'b00, 2'b00, 0, 0, 0, 2);
        rstn = 1'b1; de_counter = 5'd0;
        cyc(2'b01, 2'b01, 2'b01, 1, 0, 0, 0);

        phase = "drain";
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected responses never compared, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  in  1  clock; all state updates on posedge clk.
REQ-002 rstn  in  1  reset, synchronous, active-low.
REQ-003 d_rs, d_rt  in  5 each  source register indices of the instruction in D.
REQ-004 d_uses_rs, d_uses_rt  in  1 each  D instruction reads rs / rt.
REQ-005 de_rd  in  5  destination index of the instruction in E.
REQ-006 de_is_load  in  1  E instruction is a load; its result is available only after E.
REQ-007 de_mem  in  1  E instruction accesses memory.
REQ-008 mem_ready  in  1  memory completes the E access this cycle.
REQ-009 de_counter  in  5  extra execute cycles needed by the E instruction; 0 means single-cycle.
REQ-010 e_redirect  in  1  E resolved a taken branch, jump or jr.
REQ-011 de_stop  in  1  E instruction is a stop.
REQ-012 fd_update, de_update, ew_update  out  2 each  pipeline-register commands: 00 HOLD, 01 LOAD, 10 FLUSH; 11 is never driven.
REQ-013 pc_en  out  1  PC loads its next value (sequential or redirect target).
REQ-014 mem_req  out  1  memory access is valid this cycle.
REQ-015 halted  out  1  controller is in HALT.
REQ-016 stall_cnt  out  32  count of cycles with pc_en=0 outside HALT.

Function
REQ-017 States: RUN, EXEC_WAIT, MEM_WAIT, HALT; a 5-bit internal counter cnt.
REQ-018 Outputs are combinational from state, cnt and inputs; no added latency.
REQ-019 "Advance" means evaluating the following in priority order.
- (a) Memory not ready (de_mem=1 and mem_ready=0): enter MEM_WAIT; fd=HOLD, de=HOLD, ew=FLUSH, pc_en=0.
- (b) Stop (de_stop=1): fd=FLUSH, de=FLUSH, ew=LOAD, pc_en=0; enter HALT.
- (c) Redirect (e_redirect=1): fd=FLUSH, de=FLUSH, ew=LOAD, pc_en=1.
- (d) Load-use: de_is_load=1, de_rd≠0, and (d_uses_rs and d_rs=de_rd, or d_uses_rt and d_rt=de_rd). Drive fd=HOLD, de=FLUSH, ew=LOAD, pc_en=0.
- (e) Otherwise: all LOAD, pc_en=1.
REQ-020 RUN with de_counter=N>0: fd=HOLD, de=HOLD, ew=FLUSH, pc_en=0; cnt<=N-1; next state EXEC_WAIT.
REQ-021 RUN with de_counter=0: advance; remain in RUN unless (a) or (b) applies.
REQ-022 EXEC_WAIT with cnt≠0: hold as in REQ-020; cnt decrements.
REQ-023 EXEC_WAIT with cnt=0: advance; return to RUN unless (a) or (b) applies. An instruction with de_counter=N therefore occupies E for N+1 cycles.
REQ-024 MEM_WAIT: hold as in (a) while mem_ready=0; on mem_ready=1, advance, skipping check (a).
REQ-025 mem_req=de_mem in RUN with de_counter=0, in EXEC_WAIT with cnt=0, and in MEM_WAIT; otherwise 0.
REQ-026 HALT: all updates HOLD, pc_en=0, mem_req=0, halted=1; HALT exits only on reset.
REQ-027 stall_cnt increments by 1, wrapping modulo 2^32, on every cycle with pc_en=0 and state≠HALT.
REQ-028 A redirect and a load-use hazard together resolve as redirect; the hazard disappears with the flushed D instruction.

Reset
REQ-029 While rstn=0: state<=RUN, cnt<=0, stall_cnt<=0; all update outputs 00, pc_en=0, mem_req=0, halted=0.
REQ-030 Reset asserted in any state, including mid-EXEC_WAIT or MEM_WAIT, abandons the operation; the first cycle after release is in RUN.

Structure
REQ-031 Package pipe_ctrl_pkg holds update_t (HOLD=2'b00, LOAD=2'b01, FLUSH=2'b10), state_t, and CNT_W=5.
REQ-032 Load-use comparison lives in a combinational sub-module hazard_detect (inputs d_rs, d_rt, d_uses_*, de_rd, de_is_load; output hazard).

Verification
REQ-033 Straight-line code with no hazards -> all updates 01 and pc_en=1 every cycle; stall_cnt stays 0.
REQ-034 Load to r5 in E, D reads rs=5 -> one cycle of fd=00, de=10, ew=01, pc_en=0, then all 01; stall_cnt=1. The same case with de_rd=0 -> no stall.
REQ-035 de_counter=3 -> three cycles of 00/00/10 with pc_en=0, then an advance cycle; E residency 4 cycles; stall_cnt=3.
REQ-036 de_mem=1 with mem_ready low for 2 cycles -> MEM_WAIT for 2 cycles, then advance on mem_ready=1; mem_req high throughout.
REQ-037 e_redirect=1 together with a load-use match -> fd=10, de=10, ew=01, pc_en=1. de_stop=1 -> HALT with halted=1 and all updates 00 until rstn=0; after reset the controller is in RUN.
